dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of the number of 32-bit memory words.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response (legal 0..15).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  a MEM-stage access request is present.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  the responder accepts a request this cycle.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  the requester consumes the response this cycle.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  the access was misaligned.
REQ-014 access_count  output  16  number of completed responses, saturating.

Function
REQ-015 The memory SHALL be 2^DEPTH_LOG2 words, indexed by req_addr[DEPTH_LOG2+1:2]; upper address bits are ignored (address wraps).
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 A request is accepted in cycle T when state is IDLE and req_valid=1; req_we, addr and wdata SHALL be latched at that edge.
REQ-018 On acceptance, IDLE->WAIT with wait counter=LATENCY when LATENCY>0; IDLE->RESP directly when LATENCY=0.
REQ-019 In WAIT the counter SHALL decrement each cycle; the edge at which it goes 1->0 moves WAIT->RESP.
REQ-020 rsp_valid SHALL first be high in cycle T+1+LATENCY.
REQ-021 The memory access SHALL commit on the edge that enters RESP: stores write the latched word; loads register the word into rsp_rdata.
REQ-022 If addr[1:0]!=0: no write, rsp_err=1 and rsp_rdata=0 for that response; otherwise rsp_err=0.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL stay stable in RESP until rsp_ready=1; on rsp_valid&&rsp_ready, RESP->IDLE.
REQ-024 There is no request pipelining: a new request is accepted no earlier than the cycle after the handshake; req_valid in WAIT/RESP SHALL be ignored, and the requester holds it.
REQ-025 access_count SHALL increment on each rsp_valid&&rsp_ready, saturating at 16'hFFFF (no wrap).
REQ-026 rsp_ready while not in RESP SHALL have no effect.
REQ-027 A load to the same word as the immediately preceding completed store SHALL return the stored value.

Reset
REQ-028 On a clk edge with rst=1, the block SHALL enter IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, access_count=0 and the wait counter at 0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 Reset in WAIT SHALL discard the pending access: no write occurs and no response is produced.
REQ-031 Reset in RESP SHALL drop the response without incrementing access_count.
REQ-032 rst SHALL take priority over every simultaneous handshake.

Verification
REQ-033 LATENCY=2: store addr 0x10, data 0xDEADBEEF accepted at T -> rsp_valid at T+3 with rsp_err=0 and rsp_rdata=0; a later load at 0x10 returns 0xDEADBEEF; access_count=2.
REQ-034 LATENCY=0: load accepted at T -> rsp_valid at T+1; with rsp_ready held low for 5 cycles, outputs stay stable, req_ready=0 and a second req_valid is ignored.
REQ-035 Load addr 0x13 -> rsp_err=1 and rsp_rdata=0; a preceding store to 0x13 leaves word 4 unchanged.
REQ-036 DEPTH_LOG2=8: store at 0x400 then load at 0x000 -> returns the stored value (wrap).
REQ-037 rst asserted during WAIT of a store to 0x20 -> IDLE next cycle, rsp_valid never rises, and a load at 0x20 returns the old value.
REQ-038 Force access_count to 0xFFFE and complete 3 responses -> the counter reads 0xFFFF and holds.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data memory responder for a MEM-stage request/response handshake.
// One access in flight at a time; fixed LATENCY wait cycles before the response.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request latched, counting down LATENCY cycles
// RESP  | response held on rsp_* until rsp_ready
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] access_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        enter_resp;
  logic        handshake;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_aligned;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic        unused_addr_bits;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] count_q;

  // With LATENCY=0 the access commits on the accept edge, before the latches hold it.
  assign acc_we      = (state == IDLE) ? req_we    : we_q;
  assign acc_addr    = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata   = (state == IDLE) ? req_wdata : wdata_q;
  assign acc_aligned = (acc_addr[1:0] == 2'b00);
  assign acc_idx     = acc_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^acc_addr[31:DEPTH_LOG2+2];

  assign req_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign handshake    = (state == RESP) && rsp_ready;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign access_count = count_q;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    enter_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (enter_resp) begin
        rdata_q <= (!acc_we && acc_aligned) ? mem[acc_idx] : 32'd0;
        err_q   <= !acc_aligned;
      end
      if (handshake && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Memory is deliberately left out of reset; a reset mid-access blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && acc_aligned) mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized accesses checked
// against a word-array memory model, response-latency count and saturating counter.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] access_count;

  logic        req_valid0, req_we0, rsp_ready0;
  logic [31:0] req_addr0, req_wdata0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [15:0] access_count0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .access_count(access_count)
  );

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_ready(req_ready0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .access_count(access_count0)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] mem_model [256];
  logic [15:0] cnt_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access on the LATENCY=2 instance; junk req_valid is driven while busy.
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          idx, n;
    idx       = int'((addr >> 2) % 256);
    exp_err   = (addr % 4) != 0;
    exp_rdata = (!we && !exp_err) ? mem_model[idx] : 32'd0;
    if (we && !exp_err) mem_model[idx] = wdata;

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    n = 0;
    forever begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = $urandom; req_wdata = $urandom;
      if (rsp_valid || n > 40) break;
      n++;
    end
    check("rsp_latency", 32'(n), 32'(LAT));
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("req_ready_busy", 32'(req_ready), 32'd0);
      rsp_ready = (i == hold);
      req_valid = (i == hold) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after", 32'(rsp_valid), 32'd0);
    check("access_count", 32'(access_count), 32'(cnt_model));
  endtask

  task automatic acc0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0;
    check("l0_rsp_valid", 32'(rsp_valid0), 32'd1);
    rsp_ready0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready0 = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic        w;
    rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 0;
    cnt_model = 16'd0;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_count", 32'(access_count), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stray_rsp_ready", 32'(access_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // memory contents after power-up are unknown; seed every word the bench reads
    for (int i = 0; i < 16; i++) do_access(1'b1, 32'(i * 4), $urandom, 0);
    for (int i = 64; i < 72; i++) do_access(1'b1, 32'(i * 4), $urandom, 0);

    // store/load basic and count
    cnt_model = 16'd0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    do_access(1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_access(1'b0, 32'h10, 32'h0, 1);
    check("count_two", 32'(access_count), 32'd2);

    // misaligned store leaves word 4 alone, misaligned load errors
    do_access(1'b1, 32'h13, 32'h55555555, 0);
    do_access(1'b0, 32'h13, 32'h0, 0);
    do_access(1'b0, 32'h10, 32'h0, 0);

    // address wrap
    do_access(1'b1, 32'h400, 32'hCAFEF00D, 2);
    do_access(1'b0, 32'h000, 32'h0, 0);

    // reset during WAIT of a store
    do_access(1'b1, 32'h20, 32'hA5A5A5A5, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("wait_no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_model = 16'd0;
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    check("rstw_count", 32'(access_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_access(1'b0, 32'h20, 32'h0, 0);

    // randomized traffic over seeded words, random upper address bits
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      do_access(w, a, d, $urandom_range(0, 3));
    end

    // LATENCY=0 instance: one-cycle response, hold stability, ignored request
    acc0(1'b1, 32'h10, 32'h12345678);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_we0 = 1'b1; req_addr0 = 32'h14; req_wdata0 = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      check("l0_hold_valid", 32'(rsp_valid0), 32'd1);
      check("l0_hold_rdata", rsp_rdata0, 32'h12345678);
      check("l0_hold_err", 32'(rsp_err0), 32'd0);
      check("l0_hold_ready", 32'(req_ready0), 32'd0);
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b1;
    @(negedge clk);
    rsp_ready0 = 1'b0;
    check("l0_done", 32'(rsp_valid0), 32'd0);
    check("l0_count", 32'(access_count0), 32'd2);
    @(negedge clk);
    check("l0_ignored", 32'(rsp_valid0), 32'd0);

    // saturation
    @(negedge clk);
    u_dut.count_q = 16'hFFFE;
    cnt_model = 16'hFFFE;
    for (int i = 0; i < 3; i++) do_access(1'b0, 32'h10, 32'h0, 0);
    check("count_sat", 32'(access_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
